// File: rtl/intdiv_sched.sv
// Shares one free-running pipelined divider between two requesters: round-robin issue,
// a tag/valid slot pipeline matching the divider latency, and credit-guarded result FIFOs.
module intdiv_sched #(
  parameter int N       = 4,
  parameter int LATENCY = 6,
  parameter int DEPTH   = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         req0_valid_i,
  output logic         req0_ready_o,
  input  logic [N-1:0] req0_x_i,
  input  logic [N-1:0] req0_y_i,
  input  logic         req1_valid_i,
  output logic         req1_ready_o,
  input  logic [N-1:0] req1_x_i,
  input  logic [N-1:0] req1_y_i,
  output logic [N-1:0] div_x_o,
  output logic [N-1:0] div_y_o,
  input  logic [N-1:0] div_z_i,
  input  logic [N-1:0] div_r_i,
  output logic         res0_valid_o,
  input  logic         res0_ready_i,
  output logic [N-1:0] res0_z_o,
  output logic [N-1:0] res0_r_o,
  output logic         res0_dbz_o,
  output logic         res1_valid_o,
  input  logic         res1_ready_i,
  output logic [N-1:0] res1_z_o,
  output logic [N-1:0] res1_r_o,
  output logic         res1_dbz_o,
  output logic         busy_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = 2 * N + 1;

  logic [1:0]   req_valid, res_ready, elig, grant, push, pop;
  logic [N-1:0] req_x [2];
  logic [N-1:0] req_y [2];

  logic         rr_q, rr_d;
  logic         accept, acc_tag;
  logic [N-1:0] acc_x, acc_y;
  logic [N-1:0] div_x_q, div_y_q;

  logic [LATENCY-1:0] sv_q, st_q, sd_q;
  logic [N-1:0]       sx_q [LATENCY];

  logic [CW-1:0] cnt_q [2];
  logic [CW-1:0] occ_q [2];
  logic [AW-1:0] wp_q [2];
  logic [AW-1:0] rp_q [2];
  logic [EW-1:0] mem_q [2][DEPTH];
  logic [EW-1:0] wb_data;
  logic [EW-1:0] head [2];

  assign req_valid = {req1_valid_i, req0_valid_i};
  assign res_ready = {res1_ready_i, res0_ready_i};
  assign req_x[0]  = req0_x_i;
  assign req_x[1]  = req1_x_i;
  assign req_y[0]  = req0_y_i;
  assign req_y[1]  = req1_y_i;

  always_comb begin
    elig    = '0;
    grant   = '0;
    push    = '0;
    pop     = '0;
    head[0] = '0;
    head[1] = '0;
    for (int i = 0; i < 2; i++) begin
      // cnt counts in-flight plus buffered ops, so a grant always has a FIFO slot waiting
      elig[i] = req_valid[i] && (cnt_q[i] < CW'(DEPTH));
      push[i] = sv_q[LATENCY-1] && (st_q[LATENCY-1] == 1'(i));
      pop[i]  = (occ_q[i] != '0) && res_ready[i];
      if (occ_q[i] != '0) head[i] = mem_q[i][rp_q[i]];
    end
    if (&elig) grant[rr_q] = 1'b1;
    else       grant = elig;
    accept  = |grant;
    acc_tag = grant[1];
    acc_x   = req_x[acc_tag];
    acc_y   = req_y[acc_tag];
    rr_d    = accept ? ~acc_tag : rr_q;
    wb_data = sd_q[LATENCY-1] ? {1'b1, sx_q[LATENCY-1], {N{1'b1}}}
                              : {1'b0, div_r_i, div_z_i};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q    <= 1'b0;
      div_x_q <= '0;
      div_y_q <= '0;
      sv_q    <= '0;
      st_q    <= '0;
      sd_q    <= '0;
      for (int k = 0; k < LATENCY; k++) sx_q[k] <= '0;
      for (int i = 0; i < 2; i++) begin
        cnt_q[i] <= '0;
        occ_q[i] <= '0;
        wp_q[i]  <= '0;
        rp_q[i]  <= '0;
        for (int d = 0; d < DEPTH; d++) mem_q[i][d] <= '0;
      end
    end else begin
      rr_q <= rr_d;
      if (accept) begin
        div_x_q <= acc_x;
        div_y_q <= acc_y;
      end
      sv_q    <= {sv_q[LATENCY-2:0], accept};
      st_q    <= {st_q[LATENCY-2:0], acc_tag};
      sd_q    <= {sd_q[LATENCY-2:0], (acc_y == '0)};
      sx_q[0] <= acc_x;
      for (int k = 1; k < LATENCY; k++) sx_q[k] <= sx_q[k-1];
      for (int i = 0; i < 2; i++) begin
        cnt_q[i] <= cnt_q[i] + CW'(grant[i]) - CW'(pop[i]);
        occ_q[i] <= occ_q[i] + CW'(push[i]) - CW'(pop[i]);
        if (push[i]) begin
          mem_q[i][wp_q[i]] <= wb_data;
          wp_q[i] <= (wp_q[i] == AW'(DEPTH - 1)) ? '0 : wp_q[i] + 1'b1;
        end
        if (pop[i]) rp_q[i] <= (rp_q[i] == AW'(DEPTH - 1)) ? '0 : rp_q[i] + 1'b1;
      end
    end
  end

  assign req0_ready_o = grant[0];
  assign req1_ready_o = grant[1];
  assign div_x_o      = div_x_q;
  assign div_y_o      = div_y_q;

  assign res0_valid_o = occ_q[0] != '0;
  assign res0_z_o     = head[0][N-1:0];
  assign res0_r_o     = head[0][2*N-1:N];
  assign res0_dbz_o   = head[0][2*N];
  assign res1_valid_o = occ_q[1] != '0;
  assign res1_z_o     = head[1][N-1:0];
  assign res1_r_o     = head[1][2*N-1:N];
  assign res1_dbz_o   = head[1][2*N];

  assign busy_o = (cnt_q[0] != '0) || (cnt_q[1] != '0);

endmodule
